// File: rtl/if_defs.sv
// Shared instruction-fetch definitions.
// Holds the reset vector, the exception-type bit positions carried down the
// pipeline alongside each instruction, the fetch FSM state type and a small
// alignment helper. Imported by if_fetch, and meant to be imported by IF/ID
// and later stages that read the exception bits.
package if_defs;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  // Bit positions inside the 32-bit exception-type word
  localparam int unsigned INT_BIT     = 0;
  localparam int unsigned ADEL_BIT    = 4;
  localparam int unsigned ADES_BIT    = 5;
  localparam int unsigned SYSCALL_BIT = 8;
  localparam int unsigned BREAK_BIT   = 9;
  localparam int unsigned RI_BIT      = 10;
  localparam int unsigned OV_BIT      = 11;
  localparam int unsigned ERET_BIT    = 12;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // issuing (or about to issue) a read for req_addr
    S_WAIT = 2'd1,  // request accepted, waiting for read data
    S_HOLD = 2'd2   // instruction buffered and presented to IF/ID
  } fetch_state_e;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage.
// Owns the PC, issues SRAM-like reads to the instruction bridge and presents
// one instruction at a time (if_pc / if_instr / if_exception_type, qualified
// by if_valid) until the pipeline consumes it with stall == 0. Branch
// redirects are remembered until the presented instruction is consumed;
// exceptions flush the buffer and discard any read still in flight.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   stall[3:0]                   pipeline stall vector, 0 = consume
//   exception, exception_pc      flush and redirect
//   branch_flag, branch_target   taken-branch pulse from ID
//   inst_req, inst_addr          read request to the bridge
//   inst_addr_ok                 request accepted this cycle
//   inst_data_ok, inst_rdata     read data returned this cycle
//   if_pc, if_instr,
//   if_exception_type, if_valid  presented instruction
//   fetch_stall_req              fetch not ready (== !if_valid)
module if_fetch
  import if_defs::*;
#(
  parameter logic [31:0] RESET_PC = if_defs::RESET_PC,
  parameter int unsigned ADEL_BIT = if_defs::ADEL_BIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  stall,
  input  logic        exception,
  input  logic [31:0] exception_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_exception_type,
  output logic        if_valid,
  output logic        fetch_stall_req
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic         pend_br_q, pend_br_d;
  logic [31:0]  pend_tgt_q, pend_tgt_d;
  logic         cancel_q, cancel_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic [31:0]  if_exc_q, if_exc_d;
  logic [31:0]  nxt_pc;
  logic         aligned;

  assign aligned = word_aligned(req_addr_q[1:0]);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    pend_br_d  = pend_br_q;
    pend_tgt_d = pend_tgt_q;
    cancel_d   = cancel_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_exc_d   = if_exc_q;

    // A branch arriving in the consuming cycle belongs to the instruction
    // already in ID, so it redirects immediately ahead of any older pending one.
    nxt_pc = branch_flag ? branch_target
                         : (pend_br_q ? pend_tgt_q : pc_q + 32'd4);

    if (branch_flag) begin
      pend_br_d  = 1'b1;
      pend_tgt_d = branch_target;
    end
    if (exception) begin
      pc_d      = exception_pc;
      pend_br_d = 1'b0;
    end

    case (state_q)
      S_REQ: begin
        if (!aligned) begin
          // No bus cycle for a misaligned PC; present an AdEL slot instead.
          if (exception) begin
            req_addr_d = exception_pc;
          end else begin
            state_d    = S_HOLD;
            if_pc_d    = req_addr_q;
            if_instr_d = '0;
            if_exc_d   = 32'd1 << ADEL_BIT;
          end
        end else begin
          // The request must stay stable once raised, so a flush here only
          // marks the eventual response for discard.
          if (exception) cancel_d = 1'b1;
          if (inst_addr_ok) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          if (cancel_q || exception) begin
            cancel_d   = 1'b0;
            req_addr_d = exception ? exception_pc : pc_q;
            state_d    = S_REQ;
          end else begin
            if_pc_d    = req_addr_q;
            if_instr_d = inst_rdata;
            if_exc_d   = '0;
            state_d    = S_HOLD;
          end
        end else if (exception) begin
          cancel_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (exception) begin
          req_addr_d = exception_pc;
          state_d    = S_REQ;
        end else if (stall == 4'b0000) begin
          pc_d       = nxt_pc;
          req_addr_d = nxt_pc;
          pend_br_d  = 1'b0;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      pend_br_q  <= 1'b0;
      pend_tgt_q <= '0;
      cancel_q   <= 1'b0;
      if_pc_q    <= RESET_PC;
      if_instr_q <= '0;
      if_exc_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      pend_br_q  <= pend_br_d;
      pend_tgt_q <= pend_tgt_d;
      cancel_q   <= cancel_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_exc_q   <= if_exc_d;
    end
  end

  assign inst_req          = !rst && (state_q == S_REQ) && aligned;
  assign inst_addr         = req_addr_q;
  assign if_valid          = (state_q == S_HOLD);
  assign fetch_stall_req   = !if_valid;
  assign if_pc             = if_pc_q;
  assign if_instr          = if_instr_q;
  assign if_exception_type = if_exc_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios with literal expectations followed
// by randomized stall / branch / exception / reset traffic against a memory
// responder with random acceptance and latency. The reference model tracks
// only the architectural fetch stream (which PC must be presented next).
module tb_if_fetch;

  localparam logic [31:0] RPC  = 32'hBFC0_0000;
  localparam int unsigned ADEL = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  stall;
  logic        exception;
  logic [31:0] exception_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] if_exception_type;
  logic        if_valid;
  logic        fetch_stall_req;

  if_fetch #(.RESET_PC(RPC), .ADEL_BIT(ADEL)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .exception         (exception),
    .exception_pc      (exception_pc),
    .branch_flag       (branch_flag),
    .branch_target     (branch_target),
    .inst_req          (inst_req),
    .inst_addr         (inst_addr),
    .inst_addr_ok      (inst_addr_ok),
    .inst_data_ok      (inst_data_ok),
    .inst_rdata        (inst_rdata),
    .if_pc             (if_pc),
    .if_instr          (if_instr),
    .if_exception_type (if_exception_type),
    .if_valid          (if_valid),
    .fetch_stall_req   (fetch_stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory contents: memf(0xBFC0_0000) == 0x2402_0001
  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h9BC2_0001;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- stimulus side ----------------
  logic        nx_rst, nx_exc, nx_br;
  logic [3:0]  nx_stall;
  logic [31:0] nx_epc, nx_tgt;
  int          ok_pct, lat_lo, lat_hi;
  logic        ov_en;
  logic [31:0] ov_data;
  logic        mbusy;
  int          mcnt;
  logic [31:0] maddr;

  task automatic cyc();
    @(negedge clk);
    rst           = nx_rst;
    stall         = nx_stall;
    exception     = nx_exc;
    exception_pc  = nx_epc;
    branch_flag   = nx_br;
    branch_target = nx_tgt;
    #1;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    if (nx_rst) begin
      mbusy = 1'b0;
    end else if (mbusy) begin
      if (mcnt == 0) begin
        inst_data_ok = 1'b1;
        inst_rdata   = ov_en ? ov_data : memf(maddr);
        ov_en        = 1'b0;
        mbusy        = 1'b0;
      end else begin
        mcnt--;
      end
    end else if (inst_req && ($urandom_range(0, 99) < ok_pct)) begin
      inst_addr_ok = 1'b1;
      mbusy        = 1'b1;
      maddr        = inst_addr;
      mcnt         = $urandom_range(lat_lo, lat_hi);
    end
    nx_br  = 1'b0;
    nx_exc = 1'b0;
  endtask

  function automatic logic [31:0] rnd_addr();
    int unsigned r;
    logic [31:0] a;
    r = $urandom_range(0, 19);
    a = 32'hBFC0_0000 | ($urandom & 32'h0000_0FFC);
    if (r == 0)      a = 32'hFFFF_FFFC;
    else if (r <= 2) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  // ---------------- reference model + compare ----------------
  logic [31:0] m_exp, m_tgt, p_addr;
  logic        m_pend, m_out, p_valid, p_req, consumed;
  int          idle;

  initial begin
    m_exp = RPC; m_tgt = '0; m_pend = 1'b0; m_out = 1'b0;
    p_valid = 1'b0; p_req = 1'b0; p_addr = '0; idle = 0;
    forever begin
      @(posedge clk);
      #1;
      consumed = 1'b0;
      if (rst) begin
        m_exp = RPC; m_pend = 1'b0; m_out = 1'b0;
      end else begin
        if (p_req && inst_addr_ok) m_out = 1'b1;
        else if (inst_data_ok)     m_out = 1'b0;
        if (exception) begin
          m_exp  = exception_pc;
          m_pend = 1'b0;
        end else if (p_valid && stall == 4'b0000) begin
          consumed = 1'b1;
          m_exp  = branch_flag ? branch_target : (m_pend ? m_tgt : m_exp + 32'd4);
          m_pend = 1'b0;
        end else if (branch_flag) begin
          m_pend = 1'b1;
          m_tgt  = branch_target;
        end
      end

      chk("stall_req", 32'(fetch_stall_req), 32'(!if_valid));
      if (rst) begin
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_req", 32'(inst_req), 32'd0);
        chk("rst_pc", if_pc, RPC);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_exc", if_exception_type, 32'd0);
      end else begin
        if (p_valid && (consumed || exception)) chk("valid_drop", 32'(if_valid), 32'd0);
        else if (p_valid)                       chk("valid_hold", 32'(if_valid), 32'd1);
        if (p_req && !inst_addr_ok) begin
          chk("req_held", 32'(inst_req), 32'd1);
          chk("addr_stable", inst_addr, p_addr);
        end
      end
      if (if_valid) begin
        chk("if_pc", if_pc, m_exp);
        if (m_exp[1:0] != 2'b00) begin
          chk("if_instr_adel", if_instr, 32'd0);
          chk("if_exc_adel", if_exception_type, 32'd1 << ADEL);
        end else begin
          chk("if_instr", if_instr, memf(m_exp));
          chk("if_exc", if_exception_type, 32'd0);
        end
      end
      if (inst_req) begin
        chk("addr_align", 32'(inst_addr[1:0]), 32'd0);
        chk("one_outstanding", 32'(m_out), 32'd0);
      end

      if (rst || consumed) idle = 0;
      else idle++;
      if (idle > 400) begin
        checks++;
        errors++;
        $display("FAIL progress_timeout got %0d idle cycles expected <= 400", idle);
        idle = 0;
      end

      p_valid = if_valid;
      p_req   = inst_req;
      p_addr  = inst_addr;
    end
  end

  // ---------------- directed then random ----------------
  initial begin
    logic got;
    rst = 1'b1; stall = '0; exception = 1'b0; exception_pc = '0;
    branch_flag = 1'b0; branch_target = '0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
    nx_rst = 1'b1; nx_exc = 1'b0; nx_br = 1'b0; nx_stall = '0;
    nx_epc = '0; nx_tgt = '0;
    ok_pct = 100; lat_lo = 0; lat_hi = 0;
    ov_en = 1'b0; ov_data = '0; mbusy = 1'b0; mcnt = 0; maddr = '0;

    // Reset and zero-wait first fetch
    cyc(); cyc();
    chk("d_rst_req", 32'(inst_req), 32'd0);
    chk("d_rst_valid", 32'(if_valid), 32'd0);
    chk("d_rst_pc", if_pc, 32'hBFC0_0000);
    nx_rst = 1'b0;
    cyc();
    chk("d_req0", 32'(inst_req), 32'd1);
    chk("d_addr0", inst_addr, 32'hBFC0_0000);
    cyc();
    chk("d_novalid_n1", 32'(if_valid), 32'd0);
    cyc();
    chk("d_valid_n2", 32'(if_valid), 32'd1);
    chk("d_pc0", if_pc, 32'hBFC0_0000);
    chk("d_instr0", if_instr, 32'h2402_0001);
    cyc();
    chk("d_addr1", inst_addr, 32'hBFC0_0004);
    cyc();

    // Stall in HOLD for 5 cycles
    nx_stall = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("d_stall_valid", 32'(if_valid), 32'd1);
      chk("d_stall_pc", if_pc, 32'hBFC0_0004);
      chk("d_stall_noreq", 32'(inst_req), 32'd0);
    end
    nx_stall = 4'b0000;
    cyc();
    chk("d_release_valid", 32'(if_valid), 32'd1);
    lat_lo = 2; lat_hi = 2;
    cyc();
    chk("d_addr2", inst_addr, 32'hBFC0_0008);

    // Branch while WAIT
    nx_br = 1'b1; nx_tgt = 32'hBFC0_0100;
    cyc(); cyc(); cyc();
    cyc();
    chk("d_br_pc", if_pc, 32'hBFC0_0008);
    lat_lo = 3; lat_hi = 3;
    cyc();
    chk("d_br_addr", inst_addr, 32'hBFC0_0100);

    // Exception while WAIT, stale 0xDEADBEEF response dropped
    nx_exc = 1'b1; nx_epc = 32'hBFC0_0380;
    ov_en = 1'b1; ov_data = 32'hDEAD_BEEF;
    cyc();
    lat_lo = 0; lat_hi = 0;
    got = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (inst_req) begin
        got = 1'b1;
        break;
      end
      chk("d_exc_novalid", 32'(if_valid), 32'd0);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL d_exc_refetch_timeout got no inst_req expected fetch of bfc00380");
    end else begin
      chk("d_exc_addr", inst_addr, 32'hBFC0_0380);
    end

    // Branch to a misaligned target
    nx_br = 1'b1; nx_tgt = 32'hBFC0_0102;
    cyc();
    cyc();
    chk("d_exc_pc", if_pc, 32'hBFC0_0380);
    cyc();
    chk("d_mis_noreq", 32'(inst_req), 32'd0);
    cyc();
    chk("d_mis_valid", 32'(if_valid), 32'd1);
    chk("d_mis_pc", if_pc, 32'hBFC0_0102);
    chk("d_mis_instr", if_instr, 32'd0);
    chk("d_mis_exc", if_exception_type, 32'h0000_0010);

    // Reset during WAIT
    nx_exc = 1'b1; nx_epc = 32'hBFC0_0200;
    lat_lo = 3; lat_hi = 3;
    cyc();
    cyc();
    chk("d_pre_rst_addr", inst_addr, 32'hBFC0_0200);
    nx_rst = 1'b1;
    cyc();
    cyc();
    chk("d_rst_wait_req", 32'(inst_req), 32'd0);
    chk("d_rst_wait_valid", 32'(if_valid), 32'd0);
    nx_rst = 1'b0;
    cyc();
    chk("d_restart_req", 32'(inst_req), 32'd1);
    chk("d_restart_addr", inst_addr, 32'hBFC0_0000);

    // Randomized traffic
    ok_pct = 60; lat_lo = 0; lat_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      nx_rst   = ($urandom_range(0, 199) == 0);
      nx_stall = ($urandom_range(0, 9) < 6) ? 4'b0000 : 4'($urandom_range(1, 15));
      nx_exc   = ($urandom_range(0, 99) < 3);
      nx_epc   = rnd_addr();
      nx_br    = ($urandom_range(0, 99) < 8);
      nx_tgt   = rnd_addr();
      cyc();
    end
    nx_rst = 1'b0; nx_stall = '0;
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage feeding the IF/ID pipeline register: owns the PC, issues SRAM-like instruction reads, and presents `if_pc`/`if_instr`/`if_exception_type` with a valid flag for IF/ID to capture when `stall == 4'b0000`. Handles pipeline stall, branch redirect and exception flush, including discarding in-flight responses. Sits between the instruction-side memory bridge and `if_id`.

## Interface
- `RESET_PC`, 32'hBFC0_0000, first fetch address after reset
- `ADEL_BIT`, 4, bit of `if_exception_type` flagging a misaligned-PC fetch (AdEL)
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `stall`  in  4  pipeline stall vector; fetch may advance only when `4'b0000`
- `exception`  in  1  flush; redirect to `exception_pc`
- `exception_pc`  in  32  exception handler / ERET target
- `branch_flag`  in  1  one-cycle pulse from ID: taken branch
- `branch_target`  in  32  branch target, valid with `branch_flag`
- `inst_req`  out  1  read request
- `inst_addr`  out  32  request address
- `inst_addr_ok`  in  1  request accepted this cycle
- `inst_data_ok`  in  1  read data valid this cycle
- `inst_rdata`  in  32  read data
- `if_pc`  out  32  PC of presented instruction
- `if_instr`  out  32  presented instruction
- `if_exception_type`  out  32  exception flags of presented instruction
- `if_valid`  out  1  instruction presented this cycle
- `fetch_stall_req`  out  1  fetch not ready; pipeline controller ORs into `stall`

## Operation
- Registers: `pc` (next fetch address), `req_addr`, `pend_br`/`pend_tgt`, `cancel`, output buffer, FSM state.
- States: REQ (assert `inst_req`, `inst_addr = req_addr`), WAIT (accepted, awaiting data), HOLD (instruction buffered, `if_valid = 1`).
- REQ: if `req_addr[1:0] != 0`, issue no request; go HOLD with `if_instr = 0`, `if_exception_type[ADEL_BIT] = 1`, all other bits 0. Else hold `inst_req` and `inst_addr` stable until `inst_addr_ok`, then WAIT.
- WAIT: on `inst_data_ok`, if `cancel`: drop data, clear `cancel`, load `req_addr <= pc`, go REQ; else capture `inst_rdata`, `if_pc <= req_addr`, `if_exception_type <= 0`, go HOLD.
- HOLD: when `stall == 4'b0000` the instruction is consumed: `pc`/`req_addr` <= `pend_br ? pend_tgt : pc + 4` (wraps mod 2^32), clear `pend_br`, go REQ. Otherwise hold all outputs unchanged.
- `branch_flag` in any state sets `pend_br`, `pend_tgt <= branch_target` (a second pulse overwrites).
- `exception`: `pc <= exception_pc`, `pend_br <= 0`, drop HOLD buffer (`if_valid` 0 next cycle). In HOLD → REQ at `exception_pc`. In WAIT → `cancel <= 1`. In REQ: with `inst_addr_ok` same cycle → WAIT with `cancel = 1`; without → keep request stable, set `cancel`; after acceptance go WAIT and drop its data.
- Priority: `rst` > `exception` > `branch_flag` > sequential.
- `fetch_stall_req = !if_valid`, decoded from state only; no combinational path from `stall`.

## Timing
- Reset (cycle `rst` high): state REQ, `pc = req_addr = RESET_PC`, `inst_req = 0` during reset, `if_valid = 0`, `if_pc = RESET_PC`, `if_instr = 0`, `if_exception_type = 0`, `cancel = pend_br = 0`. Reset mid-transaction abandons it; the memory bridge is reset by the same `rst`.
- `inst_data_ok` arrives no earlier than cycle after `inst_addr_ok`; one outstanding request max.
- Best case: `inst_req` at N, `inst_addr_ok` at N, `inst_data_ok` at N+1, `if_valid` at N+2; consumed at N+2 → next `inst_req` at N+3.
- Misaligned PC: `if_valid` one cycle after entering REQ, no bus activity.

## Structure
- Shared package `if_defs`: `RESET_PC`, `ADEL_BIT`, state encoding, exception-type bit constants shared with IF/ID and later stages.
- Single module; no sub-module.

## Test plan
- Reset release, memory returns 0x2402_0001 with zero wait → `inst_addr` 0xBFC0_0000, `if_valid` two cycles after `inst_req`, `if_pc` 0xBFC0_0000; next `inst_addr` 0xBFC0_0004.
- `stall = 4'b0010` for 5 cycles in HOLD → outputs frozen, no `inst_req`; on release, next fetch at `pc + 4`.
- `branch_flag` with target 0xBFC0_0100 while WAIT → current instruction delivered, following fetch at 0xBFC0_0100.
- `exception` (`exception_pc` 0xBFC0_0380) in WAIT, `inst_data_ok` 3 cycles later with 0xDEAD_BEEF → data dropped, `if_valid` stays 0, next `inst_addr` 0xBFC0_0380.
- Branch to 0xBFC0_0102 → no `inst_req`; `if_valid` with `if_instr` 0, `if_exception_type = 1 << ADEL_BIT`, `if_pc` 0xBFC0_0102.
- `rst` asserted during WAIT → next cycle `inst_req` 0, `if_valid` 0; after release fetch restarts at 0xBFC0_0000.
